// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves, every cycle, which pipeline registers hold and which load a NOP.
// It also sequences multi-cycle mult/div operations that occupy EX for
// MD_LAT cycles.
//
// Parameters:
//   MD_LAT        total EX-occupancy cycles of a mult/div op (2..255)
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   id_rs, id_rt  source register fields of the ID instruction
//   id_use_rt     the ID instruction reads rt
//   ex_is_load    the EX instruction is a load
//   ex_wd         destination register of the EX instruction
//   ex_md_start   the EX instruction is a multi-cycle mult/div
//   branch_taken  a branch in ID resolved taken
//   mem_stall_req the MEM stage is not ready
//   stall[4:0]    hold enables: PC, IF_ID, ID_EX, EX_MEM, MEM_WB
//   bubble[4:0]   load NOP into the named register (same order, bit0 = 0)
//   md_done       final stalled cycle of a mult/div; EX latches its result
//   busy          FSM is waiting on a mult/div
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MD_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rt,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wd,
  input  logic       ex_md_start,
  input  logic       branch_taken,
  input  logic       mem_stall_req,
  output logic [4:0] stall,
  output logic [4:0] bubble,
  output logic       md_done,
  output logic       busy
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // The start cycle is stall cycle 1, so the counter covers the remaining ones.
  localparam logic [7:0] CNT_INIT = 8'(MD_LAT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       md_served, md_served_nxt;

  logic       load_use;
  logic       md_accept;
  logic       md_last;
  logic [4:0] stall_raw;
  logic [4:0] bubble_raw;

  assign load_use = ex_is_load && (ex_wd != 5'd0) &&
                    ((ex_wd == id_rs) || (id_use_rt && (ex_wd == id_rt)));

  // md_served blocks the same instruction from restarting while it still
  // sits in EX after completion; mem stalls must not block acceptance.
  assign md_accept = (state == RUN) && ex_md_start && !md_served;
  assign md_last   = (state == MD_WAIT) && (cnt == 8'd1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 8'd0;
      md_served <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      md_served <= md_served_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (md_accept) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      MD_WAIT: begin
        // Counts down even under a mem stall; the op keeps computing.
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase

    // Served flag lives until the ID_EX hold drops, which may be later than
    // completion if a mem stall overlaps the end of the op.
    if (md_last)            md_served_nxt = 1'b1;
    else if (!stall_raw[2]) md_served_nxt = 1'b0;
    else                    md_served_nxt = md_served;
  end

  // -------------------------------------------------------------------------
  // Output logic: fixed priority, first match wins
  // -------------------------------------------------------------------------
  always_comb begin
    stall_raw  = 5'b00000;
    bubble_raw = 5'b00000;
    if (mem_stall_req) begin
      stall_raw  = 5'b01111;
      bubble_raw = 5'b10000;
    end else if ((state == MD_WAIT) || md_accept) begin
      stall_raw  = 5'b00111;
      bubble_raw = 5'b01000;
    end else if (load_use) begin
      // Load-use beats a taken branch: the branch stays in ID and is
      // re-evaluated next cycle with the forwarded operand.
      stall_raw  = 5'b00011;
      bubble_raw = 5'b00100;
    end else if (branch_taken) begin
      bubble_raw = 5'b00010;
    end

    stall   = rst ? 5'b00000 : stall_raw;
    bubble  = rst ? 5'b00000 : bubble_raw;
    md_done = !rst && md_last;
    busy    = !rst && (state == MD_WAIT);
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL take parameter MD_LAT, default 8: total EX-occupancy cycles of a multi-cycle mult/div op; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: clock. All state is updated on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port id_rs, input, 5: rs field of the instruction in ID.
REQ-005 SHALL have port id_rt, input, 5: rt field of the instruction in ID.
REQ-006 SHALL have port id_use_rt, input, 1: the ID instruction reads rt.
REQ-007 SHALL have port ex_is_load, input, 1: the EX instruction is a load.
REQ-008 SHALL have port ex_wd, input, 5: destination register of the EX instruction.
REQ-009 SHALL have port ex_md_start, input, 1: the EX instruction is a multi-cycle mult/div.
REQ-010 SHALL have port branch_taken, input, 1: a branch in ID resolved taken.
REQ-011 SHALL have port mem_stall_req, input, 1: the MEM stage is not ready.
REQ-012 SHALL have port stall, output, 5: hold enables. bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB.
REQ-013 SHALL have port bubble, output, 5: the named pipeline register loads a NOP (all-zero) this edge; same bit order; bit0 is always 0.
REQ-014 SHALL have port md_done, output, 1: final stalled cycle of a mult/div; EX latches its result.
REQ-015 SHALL have port busy, output, 1: high when the FSM is not in RUN.

Function
REQ-016 SHALL implement FSM states RUN and MD_WAIT, an 8-bit down-counter cnt, and a flag md_served.
REQ-017 SHALL detect load-use as: ex_is_load & ex_wd!=0 & (ex_wd==id_rs | (id_use_rt & ex_wd==id_rt)).
REQ-018 SHALL resolve stall/bubble combinationally each cycle with this priority, first match wins:
 - mem_stall_req: stall=01111, bubble=10000.
 - state MD_WAIT, or a mult/div start accepted this cycle: stall=00111, bubble=01000.
 - load-use: stall=00011, bubble=00100.
 - branch_taken: stall=00000, bubble=00010 (IF_ID flushed).
 - otherwise: stall=00000, bubble=00000.
REQ-019 SHALL accept a mult/div start when state==RUN, ex_md_start=1, and md_served=0; mem_stall_req does not block acceptance.
REQ-020 On an accepted start, SHALL load cnt=MD_LAT-1 and move to MD_WAIT; the start cycle counts as stall cycle 1.
REQ-021 In MD_WAIT, SHALL decrement cnt every cycle regardless of mem_stall_req; when cnt==1, SHALL assert md_done, go to RUN, and set md_served.
REQ-022 SHALL hold stall[2] for exactly MD_LAT consecutive cycles per mult/div when there is no mem stall; the next cycle is RUN with stall[2]=0.
REQ-023 SHALL ignore ex_md_start while in MD_WAIT or while md_served=1.
REQ-024 SHALL clear md_served at the end of any cycle with stall[2]=0, and keep it set while stall[2]=1.
REQ-025 On simultaneous load-use and branch_taken, SHALL apply load-use only; the branch stays in ID and is re-evaluated next cycle.
REQ-026 On mem_stall_req during MD_WAIT, SHALL output the mem-stall pattern while cnt continues; if the FSM completes during the mem stall, md_served holds until stall[2] drops.
REQ-027 SHALL make busy combinational from state: 1 in MD_WAIT, 0 in RUN.

Reset
REQ-028 While rst=1 at an edge, SHALL set state=RUN, cnt=0, md_served=0.
REQ-029 While rst=1, SHALL force stall=00000, bubble=00000, md_done=0, busy=0, regardless of other inputs.
REQ-030 SHALL let rst asserted mid-MD_WAIT abort the operation; the cycle after rst drops is RUN with no stall.

Verification
REQ-031 Load-use: ex_is_load=1, ex_wd=5, id_rs=5 for one cycle -> stall=00011, bubble=00100 that cycle; next cycle, with ex_is_load=0, stall=00000.
REQ-032 MD_LAT=8: ex_md_start held high until the instruction leaves EX -> stall[2]=1 for 8 cycles, md_done high only in cycle 8, then one RUN cycle with stall=00000 and no re-trigger.
REQ-033 Branch vs load-use: branch_taken=1 together with load-use -> bubble=00100; next cycle branch_taken=1 alone -> bubble=00010.
REQ-034 mem_stall_req high for 3 cycles starting in MD cycle 6 (MD_LAT=8) -> stall=01111 for those 3 cycles; md_done in cycle 8; stall=00000 in cycle 9; no re-trigger.
REQ-035 ex_wd=0 with ex_is_load=1 and id_rs=0 -> no stall.
REQ-036 rst pulsed in MD cycle 3 -> all outputs 0 while rst=1; busy=0 afterward; ex_md_start accepted again on the next RUN cycle.
